// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex display driver: scans DIGITS digits, one REFRESH_DIV-cycle slot each,
// with a per-frame shadow of the inputs, leading-zero blanking and ghost suppression.
module seven_segment_scanner #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 27000,
    parameter int COMMON_ANODE  = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [6:0]          segments,
    output logic                dp,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam bit INVERT = (COMMON_ANODE != 0);

    localparam logic [6:0]        SEG_OFF = INVERT ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = INVERT;
    localparam logic [DIGITS-1:0] SEL_OFF = INVERT ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_dp;
    logic                tick;
    logic                wrap_tick;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign tick      = enable && (cnt == CNT_LAST);
    assign wrap_tick = tick && (idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            if (wrap_tick) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
            end
        end
    end

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              blank;
    logic              upper_zero;
    logic [6:0]        seg_active;
    logic [DIGITS-1:0] sel_active;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        blank      = 1'b0;
        upper_zero = 1'b1;
        sel_active = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib       = shadow_value[4*i +: 4];
                cur_dp        = shadow_dp[i];
                sel_active[i] = 1'b1;
            end
        end
        // Walk from the most significant digit down; upper_zero covers nibbles i..DIGITS-1.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (shadow_value[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
            if (idx == IW'(i))
                blank = (BLANK_LEADING != 0) && upper_zero;
        end
        seg_active = blank ? 7'h00 : hex_decode(cur_nib);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments   <= SEG_OFF;
            dp         <= DP_OFF;
            digit_sel  <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_tick;
            if (!enable) begin
                segments  <= SEG_OFF;
                dp        <= DP_OFF;
                digit_sel <= SEL_OFF;
            end else begin
                segments  <= INVERT ? ~seg_active : seg_active;
                dp        <= INVERT ? ~cur_dp : cur_dp;
                // cnt==0 marks the first cycle of a slot: keep all digits dark while segments settle.
                if (cnt == '0)
                    digit_sel <= SEL_OFF;
                else
                    digit_sel <= INVERT ? ~sel_active : sel_active;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 4-cycle slots, common anode, blanking on);
// expected display cycles are queued per frame and popped one per clock.
module tb_seven_segment_scanner;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_done;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam obs_t IDLE = '{seg: 7'h7F, dp: 1'b1, sel: 4'hF, fd: 1'b0};

    seven_segment_scanner #(
        .DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(1), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .value(value), .dp_in(dp_in),
        .segments(segments), .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected observation for cycle e (0..15) of a frame displaying v/dpv.
    function automatic obs_t frame_entry(input logic [15:0] v, input logic [3:0] dpv, input int e);
        obs_t o;
        int   d;
        int   c;
        logic [15:0] upper;
        logic [3:0]  onehot;
        d      = e / 4;
        c      = e % 4;
        upper  = v >> (4 * d);
        onehot = 4'b0001 << d;
        o.seg  = (d > 0 && upper == 16'h0) ? 7'h7F : ~HEX[upper[3:0]];
        o.dp   = ~dpv[d];
        o.sel  = (c == 0) ? 4'hF : ~onehot;
        o.fd   = (e == 15);
        return o;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv, input int first, input int count);
        for (int e = first; e < first + count; e++)
            exp_q.push_back(frame_entry(v, dpv, e));
    endtask

    task automatic push_idle(input int count);
        for (int k = 0; k < count; k++)
            exp_q.push_back(IDLE);
    endtask

    task automatic run_cycles(input string tag, input int count);
        obs_t got;
        obs_t want;
        for (int k = 0; k < count; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            got = '{seg: segments, dp: dp, sel: digit_sel, fd: frame_done};
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL %s: no expectation queued, got seg=%h dp=%b sel=%h fd=%b",
                       tag, got.seg, got.dp, got.sel, got.fd);
            end else begin
                want = exp_q.pop_front();
                assert (got === want) else begin
                    n_err++;
                    $error("FAIL %s[%0d]: got seg=%h dp=%b sel=%h fd=%b, expected seg=%h dp=%b sel=%h fd=%b",
                           tag, k, got.seg, got.dp, got.sel, got.fd, want.seg, want.dp, want.sel, want.fd);
                end
            end
        end
    endtask

    task automatic check_idle_now(input string tag);
        obs_t got;
        n_vec++;
        got = '{seg: segments, dp: dp, sel: digit_sel, fd: frame_done};
        assert (got === IDLE) else begin
            n_err++;
            $error("FAIL %s: got seg=%h dp=%b sel=%h fd=%b, expected seg=%h dp=%b sel=%h fd=%b",
                   tag, got.seg, got.dp, got.sel, got.fd, IDLE.seg, IDLE.dp, IDLE.sel, IDLE.fd);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        value  = 16'h0;
        dp_in  = 4'h0;
        #3;
        check_idle_now("reset_state");

        // Release and run the first frame: shadow still zero, so "0" then three blanks.
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        value  = 16'h1234;
        push_frame(16'h0000, 4'h0, 0, 16);
        run_cycles("frame1_zero", 16);

        // Second frame shows 1234; change to ABCD mid-frame, which must stay hidden.
        push_frame(16'h1234, 4'h0, 0, 16);
        run_cycles("frame2_1234a", 6);
        value = 16'hABCD;
        run_cycles("frame2_1234b", 10);

        push_frame(16'hABCD, 4'h0, 0, 16);
        run_cycles("frame3_abcda", 8);
        value = 16'h0050;
        dp_in = 4'b1000;
        run_cycles("frame3_abcdb", 8);

        push_frame(16'h0050, 4'b1000, 0, 16);
        run_cycles("frame4_0050", 16);

        // Hold mid-slot for 10 cycles, then resume in the same slot.
        push_frame(16'h0050, 4'b1000, 0, 6);
        run_cycles("frame5_pre", 6);
        enable = 1'b0;
        push_idle(10);
        run_cycles("hold", 10);
        enable = 1'b1;
        push_frame(16'h0050, 4'b1000, 6, 10);
        run_cycles("frame5_post", 10);

        // Asynchronous reset between edges mid-frame.
        push_frame(16'h0050, 4'b1000, 0, 9);
        run_cycles("frame6_pre", 9);
        #2;
        reset = 1'b1;
        #1;
        check_idle_now("async_reset");
        value = 16'h1234;
        dp_in = 4'h0;
        @(posedge clk);
        #1;
        check_idle_now("reset_held");
        @(negedge clk);
        reset = 1'b0;
        push_frame(16'h0000, 4'h0, 0, 16);
        run_cycles("rst_frame1", 16);
        push_frame(16'h1234, 4'h0, 0, 16);
        run_cycles("rst_frame2", 16);

        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL leftover: got %0d queued expectations, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
